sub16_serial: RTL and testbench
===============================

Name: sub16_serial

Overview:
- Bit-serial 16-bit subtractor: computes a - b LSB-first, one bit per clock, through a single full-subtractor cell.
- Sequential counterpart to the combinational 16-bit adder.
- Used in the datapath wherever area beats latency, e.g. a multi-cycle ALU path or the divider built later.
- Start/busy/done handshake; result and borrow held until the next accepted start.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only in IDLE
a_i  input  WIDTH  minuend; captured on accepted start
b_i  input  WIDTH  subtrahend; captured on accepted start
busy_o  output  1  high while a subtraction is in progress (RUN)
done_o  output  1  one-cycle pulse; out_o/borrow_o valid from this cycle
out_o  output  WIDTH  a - b mod 2^WIDTH
borrow_o  output  1  1 when a < b, unsigned

Behaviour:
- Reset (rst_n_i low, async): state IDLE; busy_o=0, done_o=0, out_o=0, borrow_o=0; internal shift registers, bit counter and borrow cleared. Applies immediately, including mid-RUN; the in-flight operation is discarded with no done_o.
- States:
  - IDLE: start_i=1 at a clock edge -> capture a_i/b_i into shift registers, clear borrow, counter=0, go to RUN. start_i=0 -> stay.
  - RUN: each edge processes bit k=counter.
    - diff_k = a_k ^ b_k ^ brw.
    - brw_next = (~a_k & b_k) | (~(a_k ^ b_k) & brw).
    - diff_k shifts into the result register from the MSB side; operand registers shift right.
    - counter+1.
    - On the edge processing k=WIDTH-1: out_o <= full result, borrow_o <= final brw, go to DONE.
  - DONE: done_o=1 for exactly one cycle; next edge -> IDLE unconditionally.
- busy_o = (state==RUN), registered.
- Latency: start accepted at edge E0. RUN spans E1..E_WIDTH. done_o high in the cycle following E_WIDTH, i.e. WIDTH+1 cycles after acceptance (17 for WIDTH=16). Back-to-back throughput: one result per WIDTH+2 cycles.
- start_i ignored in RUN and DONE; no queuing. Operand changes after capture have no effect.
- out_o/borrow_o keep the previous result throughout RUN; they update only at completion and hold until the next completion or reset.
- Unsigned wrap: result is the low WIDTH bits of a - b. borrow_o = 1 iff a < b. a == b gives 0, borrow 0.

Optional Feature:
- Macro SUB16_SERIAL_FLAGS_EN.
- Defined: adds outputs zr_o (1 when out_o==0) and ng_o (out_o[WIDTH-1]).
  - Both are registered and updated at completion, together with out_o.
  - Both reset to 0.
  - They follow the existing ALU flag semantics.
- Undefined: ports absent; all other behaviour identical.

Test Plan:
- Reset, then a=0x0000, b=0x0000, pulse start -> done_o after 17 cycles; out_o=0x0000, borrow_o=0; with flags: zr_o=1, ng_o=0.
- a=0x0000, b=0x0001 -> out_o=0xFFFF, borrow_o=1; with flags: ng_o=1.
- a=0xFFFF, b=0xFFFF -> 0x0000, borrow 0. Then a=0xAAAA, b=0x3BF1 -> 0x6EB9, borrow 0. Then a=0x1234, b=0x9876 -> 0x79BE, borrow 1. Run all three back-to-back, each start issued in the cycle after the previous done_o.
- Start a=0x0005, b=0x0003; hold start_i high and change operands to 0x0001/0x0002 during RUN -> exactly one done_o, result 0x0002, borrow 0; busy_o high for exactly 16 cycles.
- Start a=0x1234, b=0x9876; drop rst_n_i at RUN cycle 8 -> outputs 0 immediately, no done_o. After release, a fresh start a=0x0010, b=0x0001 -> out_o=0x000F.
- Check out_o holds the previous value (0x79BE) during the whole RUN of the next operation, and changes only at done_o.

Source files
------------

// File: rtl/sub16_serial.sv
// sub16_serial: bit-serial unsigned subtractor, out = a - b mod 2^WIDTH,
// one bit per clock LSB-first through a single full-subtractor cell.
// Start/busy/done handshake; out_o/borrow_o hold until the next completion.
// Optional macro SUB16_SERIAL_FLAGS_EN adds registered zr_o/ng_o result flags.
module sub16_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic             borrow_o
`ifdef SUB16_SERIAL_FLAGS_EN
  ,
  output logic             zr_o,
  output logic             ng_o
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  // Minuend bits retire from the LSB end, so the vacated MSB end collects
  // the difference bits; after WIDTH shifts this register holds the result.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             a_k;
  logic             b_k;
  logic             diff_k;
  logic             brw_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Single full-subtractor cell on the current bit pair
  always_comb begin
    a_k     = a_sr[0];
    b_k     = b_sr[0];
    diff_k  = a_k ^ b_k ^ brw;
    brw_nxt = (~a_k & b_k) | (~(a_k ^ b_k) & brw);
    res_nxt = {diff_k, a_sr[WIDTH-1:1]};
  end

  // Control FSM, shift datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      out_o    <= '0;
      borrow_o <= 1'b0;
`ifdef SUB16_SERIAL_FLAGS_EN
      zr_o     <= 1'b0;
      ng_o     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_sr   <= a_i;
            b_sr   <= b_i;
            brw    <= 1'b0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr <= res_nxt;
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          brw  <= brw_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            out_o    <= res_nxt;
            borrow_o <= brw_nxt;
`ifdef SUB16_SERIAL_FLAGS_EN
            zr_o     <= (res_nxt == '0);
            ng_o     <= res_nxt[WIDTH-1];
`endif
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: scoreboard bench for sub16_serial. Expected results come
// from a WIDTH+1-bit unsigned subtraction model pushed at each start and
// popped when done_o appears. Define SUB16_SERIAL_FLAGS_EN to cover zr_o/ng_o.
module tb_sub16_serial;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             borrow;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow;
`ifdef SUB16_SERIAL_FLAGS_EN
  logic             zr;
  logic             ng;
`endif

  exp_t             sb[$];
  int               total = 0;
  int               bad = 0;
  logic [WIDTH-1:0] last_out = '0;
  logic             last_borrow = 1'b0;

  sub16_serial #(.WIDTH(WIDTH)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .out_o    (out),
    .borrow_o (borrow)
`ifdef SUB16_SERIAL_FLAGS_EN
    ,
    .zr_o     (zr),
    .ng_o     (ng)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    exp_t e;
    d = {1'b0, x} - {1'b0, y};
    e.out = d[WIDTH-1:0];
    e.borrow = d[WIDTH];
    return e;
  endfunction

  // Issue one operation at the current negedge and check it to completion;
  // returns one negedge after done_o (IDLE cycle).
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    int   cyc;
    bit   seen;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    a = ~x;
    b = ~y;
    cyc = 1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        total++;
        if (out !== last_out || borrow !== last_borrow) begin
          bad++;
          $display("FAIL hold_during_run: got %h/%b want %h/%b", out, borrow, last_out, last_borrow);
        end
        @(negedge clk);
        cyc++;
      end
    end
    e = sb.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: no done_o within %0d cycles", cyc);
      return;
    end
    if (cyc != WIDTH + 1) begin
      bad++;
      $display("FAIL latency: got %0d want %0d", cyc, WIDTH + 1);
    end
    total++;
    if (out !== e.out || borrow !== e.borrow) begin
      bad++;
      $display("FAIL result %h-%h: got %h/%b want %h/%b", x, y, out, borrow, e.out, e.borrow);
    end
`ifdef SUB16_SERIAL_FLAGS_EN
    total++;
    if (zr !== (e.out == '0) || ng !== e.out[WIDTH-1]) begin
      bad++;
      $display("FAIL flags %h-%h: got zr=%b ng=%b want zr=%b ng=%b", x, y, zr, ng, (e.out == '0), e.out[WIDTH-1]);
    end
`endif
    last_out = e.out;
    last_borrow = e.borrow;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_end: got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b out=%h borrow=%b want 0/0/0000/0", busy, done, out, borrow);
    end
`ifdef SUB16_SERIAL_FLAGS_EN
    total++;
    if (zr !== 1'b0 || ng !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got zr=%b ng=%b want 0/0", zr, ng);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    do_op(16'h0000, 16'h0000);
    do_op(16'h0000, 16'h0001);
  endtask

  task automatic test_back_to_back();
    do_op(16'hFFFF, 16'hFFFF);
    do_op(16'hAAAA, 16'h3BF1);
    do_op(16'h1234, 16'h9876);
  endtask

  task automatic test_start_held();
    exp_t e;
    int   busy_cnt;
    int   done_cnt;
    int   cyc;
    bit   seen;
    a = 16'h0005;
    b = 16'h0003;
    start = 1'b1;
    sb.push_back(model(16'h0005, 16'h0003));
    @(negedge clk);
    a = 16'h0001;
    b = 16'h0002;
    busy_cnt = 0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        total++;
        if (out !== last_out || borrow !== last_borrow) begin
          bad++;
          $display("FAIL held_hold_during_run: got %h/%b want %h/%b", out, borrow, last_out, last_borrow);
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL held_timeout: no done_o within %0d cycles", cyc);
    end else if (out !== e.out || borrow !== e.borrow) begin
      bad++;
      $display("FAIL held_result: got %h/%b want %h/%b", out, borrow, e.out, e.borrow);
    end
    last_out = e.out;
    last_borrow = e.borrow;
    total++;
    if (busy_cnt != WIDTH) begin
      bad++;
      $display("FAIL held_busy_cycles: got %0d want %0d", busy_cnt, WIDTH);
    end
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL held_extra_done: got %0d extra pulses want 0", done_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   done_cnt;
    a = 16'h1234;
    b = 16'h9876;
    start = 1'b1;
    sb.push_back(model(16'h1234, 16'h9876));
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrun_busy: got %b want 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b out=%h borrow=%b want 0/0/0000/0", busy, done, out, borrow);
    end
`ifdef SUB16_SERIAL_FLAGS_EN
    total++;
    if (zr !== 1'b0 || ng !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_flags: got zr=%b ng=%b want 0/0", zr, ng);
    end
`endif
    e = sb.pop_front();
    last_out = '0;
    last_borrow = 1'b0;
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    total++;
    if (done_cnt != 0 || out !== '0) begin
      bad++;
      $display("FAIL discarded_op: got done pulses=%0d out=%h want 0/0000", done_cnt, out);
    end
    do_op(16'h0010, 16'h0001);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_held();
    test_reset_mid_run();
    test_random();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
